// File: rtl/hamming_decoder_rx_pkg.sv
// Shared constants, FSM state type and Hamming(7,4) syndrome helper for the
// serial frame receiver.
package hamming_decoder_rx_pkg;

  localparam int FRAME_W   = 64;
  localparam int HDR_W     = 8;
  localparam int CW_W      = 7;
  localparam int N_CW      = 8;
  localparam int PAYLOAD_W = CW_W * N_CW;
  localparam int CNT_W     = 6;

  localparam logic [HDR_W-1:0] SYNC_WORD_DEF = 8'h7E;

  typedef enum logic [1:0] {
    ST_HUNT       = 2'd0,
    ST_COLLECT    = 2'd1,
    ST_SYNC_CHECK = 2'd2
  } state_t;

  // Syndrome is the XOR of the 1-based positions of every set bit.
  function automatic logic [2:0] ham_syndrome(input logic [CW_W-1:0] cw);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < CW_W; i++) begin
      if (cw[i]) begin
        s = s ^ 3'(i + 1);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming_decoder_rx_hamming74_decode.sv
// Combinational Hamming(7,4) single-error-correcting decoder; parity at
// codeword bits 0,1,3 and data at bits 2,4,5,6.
module hamming74_decode
  import hamming_decoder_rx_pkg::*;
(
  input  logic [CW_W-1:0] cw_in,
  output logic [3:0]      nibble_out,
  output logic            corrected_out
);

  logic [2:0]      syn_s;
  logic [CW_W-1:0] fixed_s;

  // Flip the bit named by a nonzero syndrome, then extract the data nibble.
  always_comb begin
    syn_s   = ham_syndrome(cw_in);
    fixed_s = cw_in;
    if (syn_s != 3'd0) begin
      fixed_s = cw_in ^ (7'b000_0001 << (syn_s - 3'd1));
    end else begin
      fixed_s = cw_in;
    end
    nibble_out    = {fixed_s[6], fixed_s[5], fixed_s[4], fixed_s[2]};
    corrected_out = (syn_s != 3'd0);
  end

endmodule

// File: rtl/hamming_decoder_rx.sv
// Serial frame receiver: hunts for the sync header, collects eight Hamming(7,4)
// codewords, decodes them into a 32-bit word and offers it on a valid/ready port.
module hamming_decoder_rx
  import hamming_decoder_rx_pkg::*;
#(
  parameter logic [HDR_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [3:0]  err_corrected,
  output logic        locked,
  output logic        frame_drop
);

  state_t                 state_q, state_d;
  logic [HDR_W-1:0]       hdr_q, hdr_d, hdr_shift_s;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   locked_q, locked_d;
  logic [31:0]            word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic [3:0]             err_q, err_d;
  logic                   drop_q, drop_d;
  logic                   handshake_s;
  logic [31:0]            dec_word_s;
  logic [N_CW-1:0]        corr_s;
  logic [3:0]             err_sum_s;

  genvar k;
  generate
    for (k = 0; k < N_CW; k++) begin : g_dec
      hamming74_decode u_dec (
        .cw_in         (payload_q[CW_W*k +: CW_W]),
        .nibble_out    (dec_word_s[4*k +: 4]),
        .corrected_out (corr_s[k])
      );
    end
  endgenerate

  // Count how many codewords in the held payload needed a correction.
  always_comb begin
    err_sum_s = 4'd0;
    for (int i = 0; i < N_CW; i++) begin
      err_sum_s = err_sum_s + {3'd0, corr_s[i]};
    end
  end

  // Framing FSM: only qualified bits move state, shift registers or counters.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    payload_d   = payload_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    hdr_shift_s = {hdr_q[HDR_W-2:0], bit_in};
    if (bit_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (hdr_shift_s == SYNC_WORD) begin
            state_d = ST_COLLECT;
            hdr_d   = {HDR_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            hdr_d   = hdr_shift_s;
          end
        end
        ST_COLLECT: begin
          payload_d = {payload_q[PAYLOAD_W-2:0], bit_in};
          if (cnt_q == 6'd55) begin
            state_d = ST_SYNC_CHECK;
            cnt_d   = {CNT_W{1'b0}};
            hdr_d   = {HDR_W{1'b0}};
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 6'd1;
          end
        end
        ST_SYNC_CHECK: begin
          // A failed header is dropped whole; hunting restarts from a clean register.
          if (cnt_q == 6'd7) begin
            cnt_d = {CNT_W{1'b0}};
            hdr_d = {HDR_W{1'b0}};
            if (hdr_shift_s == SYNC_WORD) begin
              state_d = ST_COLLECT;
            end else begin
              state_d = ST_HUNT;
            end
          end else begin
            hdr_d = hdr_shift_s;
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: begin
          state_d = ST_HUNT;
          hdr_d   = {HDR_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d != ST_HUNT);
  end

  // Output word buffer: load a completed frame when free or being drained, else drop it.
  always_comb begin
    handshake_s = word_valid_q & word_ready;
    word_d      = word_q;
    err_d       = err_q;
    drop_d      = 1'b0;
    if (handshake_s) begin
      word_valid_d = 1'b0;
    end else begin
      word_valid_d = word_valid_q;
    end
    if (done_q) begin
      if (!word_valid_q || handshake_s) begin
        word_d       = dec_word_s;
        err_d        = err_sum_s;
        word_valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else begin
      drop_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      hdr_q        <= {HDR_W{1'b0}};
      payload_q    <= {PAYLOAD_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      done_q       <= 1'b0;
      locked_q     <= 1'b0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
      err_q        <= 4'd0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      payload_q    <= payload_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      locked_q     <= locked_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
    end
  end

  assign word_out      = word_q;
  assign word_valid    = word_valid_q;
  assign err_corrected = err_q;
  assign locked        = locked_q;
  assign frame_drop    = drop_q;

endmodule

// File: tb/tb_hamming_decoder_rx.sv
// Scoreboard bench for hamming_decoder_rx: directed frames push expected words,
// a negedge monitor pops and compares on every accepted word.
module tb_hamming_decoder_rx;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        word_ready = 1'b1;
  logic [31:0] word_out;
  logic        word_valid;
  logic [3:0]  err_corrected;
  logic        locked;
  logic        frame_drop;

  logic [35:0] exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int gap_ctr = 0;
  int drop_cnt = 0;
  int n_words = 0;
  int n_pushed = 0;
  logic watch_lock = 1'b0;
  logic lock_lost = 1'b0;

  hamming_decoder_rx #(.SYNC_WORD(8'h7E)) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .err_corrected (err_corrected),
    .locked        (locked),
    .frame_drop    (frame_drop)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: count drop pulses, watch lock, compare each accepted word.
  always @(negedge clk_in) begin : mon
    logic [35:0] e;
    if (frame_drop === 1'b1) drop_cnt++;
    if (watch_lock && locked !== 1'b1) lock_lost = 1'b1;
    if (!rst && word_valid === 1'b1 && word_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_word: got %h err %0d, expected none", word_out, err_corrected);
      end else begin
        e = exp_q.pop_front();
        check("word", {err_corrected, word_out}, e);
        n_words++;
      end
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic p1, p2, p4;
    p1 = n[0] ^ n[1] ^ n[3];
    p2 = n[0] ^ n[2] ^ n[3];
    p4 = n[1] ^ n[2] ^ n[3];
    return {n[3], n[2], n[1], p4, n[0], p2, p1};
  endfunction

  // One qualified bit; every 11th bit is preceded by an idle cycle.
  task automatic send_bit(input logic b);
    gap_ctr++;
    if (gap_ctr % 11 == 0) begin
      bit_valid = 1'b0;
      @(posedge clk_in); #1;
    end
    bit_in = b;
    bit_valid = 1'b1;
    @(posedge clk_in); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  function automatic logic [63:0] mk_frame(input logic [7:0] hdr, input logic [31:0] w,
                                           input logic [55:0] flips);
    logic [63:0] f;
    f[63:56] = hdr;
    for (int k = 0; k < 8; k++) f[7*k +: 7] = enc(w[4*k +: 4]);
    f[55:0] = f[55:0] ^ flips;
    return f;
  endfunction

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] w,
                            input logic [55:0] flips, input bit expect_word);
    logic [3:0] ne;
    ne = 4'd0;
    for (int k = 0; k < 8; k++) if (flips[7*k +: 7] != 7'd0) ne = ne + 4'd1;
    if (expect_word) begin
      exp_q.push_back({ne, w});
      n_pushed++;
    end
    send_bits(mk_frame(hdr, w, flips), 64);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk_in);
    #1;
    check("drain_timeout", 36'(exp_q.size()), 36'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_word_out"}, {4'd0, word_out}, 36'd0);
    check({tag, "_word_valid"}, {35'd0, word_valid}, 36'd0);
    check({tag, "_err"}, {32'd0, err_corrected}, 36'd0);
    check({tag, "_locked"}, {35'd0, locked}, 36'd0);
    check({tag, "_drop"}, {35'd0, frame_drop}, 36'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk_in); #1;

    // Clean frame, latency and single-cycle valid.
    send_frame(8'h7E, 32'hA5A5A5A5, 56'd0, 1'b1);
    check("latency_pre", {35'd0, word_valid}, 36'd0);
    @(posedge clk_in); #1;
    check("latency_valid", {35'd0, word_valid}, 36'd1);
    @(posedge clk_in); #1;
    check("valid_one_cycle", {35'd0, word_valid}, 36'd0);

    // Two single-bit errors: cw0 bit3, cw7 bit6.
    send_frame(8'h7E, 32'hA5A5A5A5, (56'h1 << 3) | (56'h1 << 55), 1'b1);
    wait_drain();

    // Noise then three back-to-back frames.
    send_bits(64'hA3C5A, 20);
    send_frame(8'h7E, 32'h12345678, 56'd0, 1'b1);
    watch_lock = 1'b1;
    send_frame(8'h7E, 32'hDEADBEEF, 56'd0, 1'b1);
    send_frame(8'h7E, 32'h00000000, 56'd0, 1'b1);
    watch_lock = 1'b0;
    wait_drain();
    check("lock_held", {35'd0, lock_lost}, 36'd0);

    // Back-pressure: second frame dropped, first held.
    drop_cnt = 0;
    word_ready = 1'b0;
    send_frame(8'h7E, 32'hCAFEF00D, 56'h1 << 20, 1'b1);
    send_frame(8'h7E, 32'h0F0F1234, 56'd0, 1'b0);
    repeat (3) @(posedge clk_in);
    #1;
    check("held_valid", {35'd0, word_valid}, 36'd1);
    check("held_word", {err_corrected, word_out}, {4'd1, 32'hCAFEF00D});
    check("drop_once", 36'(drop_cnt), 36'd1);
    word_ready = 1'b1;
    send_frame(8'h7E, 32'h55AA33CC, 56'd0, 1'b1);
    wait_drain();

    // Bad header drops lock; relock on next 7E.
    send_frame(8'h7E, 32'h89ABCDEF, 56'd0, 1'b1);
    send_bits(64'h6E, 8);
    check("unlock_on_6e", {35'd0, locked}, 36'd0);
    send_frame(8'h7E, 32'h13579BDF, 56'h1 << 28, 1'b1);
    wait_drain();

    // Reset mid-frame.
    send_bits(mk_frame(8'h7E, 32'hFFFFFFFF, 56'd0) >> 26, 38);
    rst = 1'b1;
    @(negedge clk_in);
    check_zero_outputs("midrst");
    @(posedge clk_in); #1;
    rst = 1'b0;
    send_frame(8'h7E, 32'h2468ACE1, 56'd0, 1'b1);
    wait_drain();

    check("word_count", 36'(n_words), 36'(n_pushed));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_decoder_rx.md
HAMMING_DECODER_RX -- requirements
Module: hamming_decoder_rx

Interface
REQ-001 SHALL have parameter: SYNC_WORD, 8'h7E, frame header pattern to lock on.
REQ-002 SHALL have port: clk_in  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: bit_in  input  1  serial frame bit; frames arrive MSB (bit 63) first.
REQ-005 SHALL have port: bit_valid  input  1  bit_in sampled only when high; one bit per qualified cycle.
REQ-006 SHALL have port: word_out  output  32  decoded data word.
REQ-007 SHALL have port: word_valid  output  1  word_out holds an unread word.
REQ-008 SHALL have port: word_ready  input  1  consumer accepts word when word_valid && word_ready.
REQ-009 SHALL have port: err_corrected  output  4  count of codewords corrected in current word_out, 0..8.
REQ-010 SHALL have port: locked  output  1  high while in COLLECT or SYNC_CHECK.
REQ-011 SHALL have port: frame_drop  output  1  one-cycle pulse when a completed frame is discarded.

Function
REQ-012 Frame: 64 bits; [63:56] header; codeword k (k=0..7) at [7k+6:7k]; its nibble -> word_out[4k+3:4k].
REQ-013 Codeword bit i = Hamming position i+1; parity at bits 0,1,3; data nibble bits 0..3 at bits 2,4,5,6.
REQ-014 Syndrome = XOR of position indices of set bits (3 bits); nonzero flips that bit before nibble extraction, increments per-frame error count.
REQ-015 FSM states: HUNT, COLLECT, SYNC_CHECK; only bit_valid cycles advance any state.
REQ-016 HUNT: 8-bit shift register cleared on entry; on a valid bit where shifted value == SYNC_WORD -> COLLECT, bit counter = 0.
REQ-017 COLLECT: shift 56 bits into payload register; on 56th valid bit frame completes -> SYNC_CHECK with 8-bit counter cleared.
REQ-018 Frame completion: decode combinationally from payload; result registered on the cycle after the 56th bit.
REQ-019 On completion, if word_valid==0 or a handshake occurs in the same cycle: load word_out, err_corrected, set word_valid; else discard the new frame, pulse frame_drop, keep old word.
REQ-020 word_valid SHALL clear on handshake unless a new word loads in the same cycle; word_out stable while word_valid && !word_ready.
REQ-021 SYNC_CHECK: collect 8 bits; == SYNC_WORD -> COLLECT (back-to-back frames, no gap); mismatch -> HUNT.
REQ-022 Header mismatch SHALL never emit a word; mismatched SYNC_CHECK bits are not reused for hunting.
REQ-023 Latency: word_valid high 1 cycle after the clk_in edge sampling the last payload bit.
REQ-024 Gaps in bit_valid at any position SHALL not alter decoding result.

Reset
REQ-025 rst SHALL force: state HUNT, all shift/counter registers 0, word_out 0, word_valid 0, err_corrected 0, locked 0, frame_drop 0.
REQ-026 rst mid-frame SHALL discard partial frame; first valid bit after release starts hunting.

Structure
REQ-027 Shared package SHALL hold: FRAME_W=64, HDR_W=8, CW_W=7, N_CW=8, SYNC_WORD default, FSM state enum.
REQ-028 One sub-module SHALL exist: hamming74_decode (7-bit codeword in; 4-bit nibble, corrected flag out; purely combinational), instantiated 8 times.

Verification
REQ-029 Clean frame 7E + codewords of 0xA5A5A5A5 (nibble 5 -> 7'h2D, A -> 7'h52), word_ready=1 -> word_out=32'hA5A5A5A5, err_corrected=0, word_valid for 1 cycle.
REQ-030 Same frame with bit 3 of codeword 0 and bit 6 of codeword 7 flipped -> word_out=32'hA5A5A5A5, err_corrected=2.
REQ-031 Random noise 20 bits, then 3 back-to-back frames (0x12345678, 0xDEADBEEF, 0x0) -> three words in order, locked stays high across frame boundaries.
REQ-032 word_ready=0 across two frames -> first word held, frame_drop pulses once at second completion; after accept, third frame delivered.
REQ-033 Frame followed by header 6E -> one word, then locked=0, HUNT; next valid 7E frame decodes correctly.
REQ-034 rst asserted after 30 payload bits -> all outputs 0; subsequent clean frame decodes with no stale bits.
